pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program counter width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset or restart.
REQ-003 SHALL have parameter PC_LIMIT, default 16'hFFFF, highest legal fetch address.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  begin or restart execution.
REQ-008 SHALL have port stall  input  1  hold PC this cycle.
REQ-009 SHALL have port halt_i  input  1  decoded HALT opcode.
REQ-010 SHALL have port jump_i  input  1  decoded unconditional JMP.
REQ-011 SHALL have port branch_i  input  1  decoded BNE/BEQ/BLT.
REQ-012 SHALL have port cond_i  input  1  branch condition true, from ALU compare.
REQ-013 SHALL have port target_i  input  PC_W  jump or branch destination, from the decoder's jump-label lookup.
REQ-014 SHALL have port pc_o  output  PC_W  current fetch address to the instruction ROM.
REQ-015 SHALL have port fetch_valid_o  output  1  pc_o is a live fetch.
REQ-016 SHALL have port done_o  output  1  program halted normally.
REQ-017 SHALL have port fault_o  output  1  PC ran past PC_LIMIT or illegal target.
REQ-018 SHALL have port state_o  output  2  current FSM state.

Function
REQ-019 SHALL implement states IDLE=00, RUN=01, HALT=10, FAULT=11, all registered.
REQ-020 IDLE: fetch_valid_o=0; start=1 -> RUN next cycle, pc_o=RESET_PC.
REQ-021 RUN: fetch_valid_o=1; all next-PC decisions apply at the rising edge, one-cycle latency.
REQ-022 RUN with stall=1: pc_o and state hold; halt_i, jump_i, branch_i ignored.
REQ-023 RUN next-PC priority: halt_i > jump_i > (branch_i & cond_i) > pc_o+1.
REQ-024 halt_i: pc_o holds, state -> HALT, done_o=1 from the next cycle.
REQ-025 jump_i, or branch_i&cond_i: pc_o <= target_i; target_i > PC_LIMIT -> FAULT, pc_o holds.
REQ-026 branch_i with cond_i=0: pc_o <= pc_o+1.
REQ-027 Sequential increment with pc_o==PC_LIMIT: no wrap; state -> FAULT, pc_o holds, fault_o=1.
REQ-028 HALT/FAULT: fetch_valid_o=0, pc_o holds; start=1 -> pc_o=RESET_PC, state RUN, done_o/fault_o cleared, same edge.
REQ-029 start in RUN SHALL be ignored.
REQ-030 done_o and fault_o SHALL never both be 1.

Reset
REQ-031 reset=1 at a clock edge SHALL force state IDLE, pc_o=RESET_PC, fetch_valid_o=0, done_o=0, fault_o=0, and override all other inputs, including mid-RUN and stall.

Configuration
REQ-032 Macro PC_CYCLE_COUNT_EN defined: adds output cycle_cnt_o, 16 bits; it counts every cycle spent in RUN, including stall cycles, and saturates at 16'hFFFF.
REQ-033 cycle_cnt_o SHALL be cleared by reset and by any accepted start, and SHALL hold in HALT/FAULT.
REQ-034 Macro undefined: no cycle_cnt_o port, no counter logic; all other behaviour is identical.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the FSM state enum, the PC_W default, and the opcode/format constants the decoder uses.
REQ-036 The next-PC priority mux and limit check SHALL be a combinational sub-module pc_next; the FSM and registers stay in pc_sequencer.

Verification
REQ-037 reset, then start pulse, with no control inputs for 5 cycles -> pc_o sequence 0,1,2,3,4; fetch_valid_o=1 from cycle 1.
REQ-038 At pc_o=7: jump_i=1, target_i=10 -> next pc_o=10; branch_i=1, cond_i=0 -> 11; branch_i=1, cond_i=1, target_i=3 -> 3.
REQ-039 halt_i=1 together with jump_i=1 at pc_o=37 -> pc_o stays 37, done_o=1, state_o=10; start -> pc_o=0, RUN.
REQ-040 stall=1 for 3 cycles with jump_i=1 at pc_o=5 -> pc_o stays 5; release -> normal sequence resumes.
REQ-041 PC_LIMIT=20 and run to pc_o=20 -> FAULT, fault_o=1, pc_o=20; separately, jump to target_i=25 -> FAULT.
REQ-042 reset asserted mid-RUN at pc_o=12 -> IDLE, pc_o=0 next cycle; with PC_CYCLE_COUNT_EN, cycle_cnt_o=0 and counts 1..N in RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer FSM states, PC width default and decoder opcode/format constants.
package cpu_pkg;

  localparam int unsigned PcWDefault = 16;

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StHalt  = 2'b10,
    StFault = 2'b11
  } seq_state_e;

  // Instruction format: [15:12] opcode, [11:0] operand / jump label.
  localparam int unsigned InstrW   = 16;
  localparam int unsigned OpcodeW  = 4;
  localparam int unsigned OperandW = InstrW - OpcodeW;
  localparam int unsigned OpcodeLsb = OperandW;

  localparam logic [OpcodeW-1:0] OpNop  = 4'h0;
  localparam logic [OpcodeW-1:0] OpLoad = 4'h1;
  localparam logic [OpcodeW-1:0] OpStor = 4'h2;
  localparam logic [OpcodeW-1:0] OpAdd  = 4'h3;
  localparam logic [OpcodeW-1:0] OpSub  = 4'h4;
  localparam logic [OpcodeW-1:0] OpCmp  = 4'h5;
  localparam logic [OpcodeW-1:0] OpJmp  = 4'h8;
  localparam logic [OpcodeW-1:0] OpBne  = 4'h9;
  localparam logic [OpcodeW-1:0] OpBeq  = 4'hA;
  localparam logic [OpcodeW-1:0] OpBlt  = 4'hB;
  localparam logic [OpcodeW-1:0] OpHalt = 4'hF;

  function automatic logic is_branch_op(logic [OpcodeW-1:0] op);
    return (op == OpBne) || (op == OpBeq) || (op == OpBlt);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: halt > jump > taken branch > increment, with PC_LIMIT checking.
module pc_next import cpu_pkg::*; #(
  parameter int unsigned     PC_W     = PcWDefault,
  parameter logic [PC_W-1:0] PC_LIMIT = PC_W'(16'hFFFF)
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            cond_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halt_o,
  output logic            fault_o
);

  logic take_target;
  assign take_target = jump_i | (branch_i & cond_i);

  always_comb begin
    pc_o    = pc_i;
    halt_o  = 1'b0;
    fault_o = 1'b0;
    if (halt_i) begin
      halt_o = 1'b1;
    end else if (take_target) begin
      if (target_i > PC_LIMIT) begin
        fault_o = 1'b1;
      end else begin
        pc_o = target_i;
      end
    end else if (pc_i >= PC_LIMIT) begin
      // Running off the end of the program never wraps.
      fault_o = 1'b1;
    end else begin
      pc_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALT/FAULT FSM and PC register.
// Optional RUN cycle counter on cycle_cnt_o when PC_CYCLE_COUNT_EN is defined.
module pc_sequencer import cpu_pkg::*; #(
  parameter int unsigned     PC_W     = PcWDefault,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_LIMIT = PC_W'(16'hFFFF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            cond_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            done_o,
  output logic            fault_o,
`ifdef PC_CYCLE_COUNT_EN
  output logic [15:0]     cycle_cnt_o,
`endif
  output logic [1:0]      state_o
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] nxt_pc;
  logic            nxt_halt;
  logic            nxt_fault;
  logic            start_accept;

  pc_next #(
    .PC_W     (PC_W),
    .PC_LIMIT (PC_LIMIT)
  ) u_pc_next (
    .pc_i     (pc_q),
    .halt_i   (halt_i),
    .jump_i   (jump_i),
    .branch_i (branch_i),
    .cond_i   (cond_i),
    .target_i (target_i),
    .pc_o     (nxt_pc),
    .halt_o   (nxt_halt),
    .fault_o  (nxt_fault)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    start_accept = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          pc_d = nxt_pc;
          if (nxt_halt) begin
            state_d = StHalt;
          end else if (nxt_fault) begin
            state_d = StFault;
          end
        end
      end
      StIdle, StHalt, StFault: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = StRun;
          pc_d         = RESET_PC;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if ((state_q == StRun) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_cnt_o = cnt_q;
`endif

  assign pc_o          = pc_q;
  assign state_o       = state_q;
  assign fetch_valid_o = (state_q == StRun);
  assign done_o        = (state_q == StHalt);
  assign fault_o       = (state_q == StFault);

endmodule
